bus_sram_responder: RTL and testbench

Word-addressed on-chip SRAM that answers the core's data-bus request/wait protocol, i.e. the target end of `busaddr`/`rd_req`/`wr_req`/`rw_wait`. It decodes one address window and services single-word reads and writes after a configurable number of wait states. When several responders share the bus, their `rw_wait` and `rd_data` outputs are OR-combined. It sits on the data bus between the memory pipeline stage and the other bus targets.

---
 rtl/bus_sram_responder_pkg.sv | 17 +
 rtl/bus_sram_responder_sram_array.sv | 43 ++++
 rtl/bus_sram_responder.sv | 105 ++++++++++
 tb/tb_bus_sram_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_sram_responder_pkg.sv
// Shared bus-target definitions: FSM state encodings and address-window decode.
package bus_sram_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned BYTE_LANES = 4;

  // Window hit: the address bits above the word index match the base.
  function automatic logic tag_match(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned addr_w);
    return (addr >> (addr_w + 2)) == (base >> (addr_w + 2));
  endfunction

endpackage

// File: rtl/bus_sram_responder_sram_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered,
// clearable read port.
module sram_array
  import bus_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic              rd_clr_i,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wr_data_i,
  output logic [31:0]       rd_data_o
);

  logic [31:0] mem_q [0:(1 << ADDR_W) - 1];
  logic [31:0] rd_data_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned i = 0; i < BYTE_LANES; i++) begin
        if (wr_be_i[i]) mem_q[addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[addr_i];
    end else if (rd_clr_i) begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Data-bus SRAM target: window decode, wait-state FSM and combinational stall
// in front of a single-port word RAM.
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] busaddr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        rw_wait,
  output logic [31:0] rd_data
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  logic              sel;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              arr_rd_en, arr_rd_clr, arr_wr_en;

  assign sel = (rd_req | wr_req) & tag_match(busaddr, BASE_ADDR, ADDR_W);
  assign idx = busaddr[ADDR_W+1:2];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          idx_d   = idx;
          wr_d    = wr_req;
          cnt_d   = 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Any change of target or direction mid-wait abandons the access.
        if (!sel || (idx != idx_q) || (wr_req != wr_q)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS_CNT) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Nrst) begin
    if (Nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rw_wait = sel & (state_q != ST_RESP);

  // The array is addressed by the latched index; in WAIT it equals the live one.
  assign arr_rd_en  = (state_q == ST_WAIT) && (state_d == ST_RESP) && !wr_q;
  assign arr_rd_clr = (state_q == ST_RESP);
  assign arr_wr_en  = (state_q == ST_RESP) && wr_q;

  sram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i    (clk),
    .rst_i    (Nrst),
    .rd_en_i  (arr_rd_en),
    .rd_clr_i (arr_rd_clr),
    .wr_en_i  (arr_wr_en),
    .wr_be_i  (wr_be),
    .addr_i   (idx_q),
    .wr_data_i(wr_data),
    .rd_data_o(rd_data)
  );

endmodule

// File: tb/tb_bus_sram_responder.sv
// Two responders on one shared bus (0x0000-0x0FFF with 1 wait state,
// 0x1000-0x13FF with 3 wait states), checked against a word-array model.
module tb_bus_sram_responder;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] busaddr;
  logic        rd_req, wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        w1, w3;
  logic [31:0] r1, r3;

  int total = 0;
  int bad   = 0;

  logic [31:0] m1 [0:1023];
  logic [31:0] m3 [0:255];

  always #5 clk = ~clk;

  bus_sram_responder #(
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_W     (10),
    .WAIT_STATES(1)
  ) dut1 (
    .clk(clk), .Nrst(Nrst), .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .wr_be(wr_be), .rw_wait(w1), .rd_data(r1)
  );

  bus_sram_responder #(
    .BASE_ADDR  (32'h0000_1000),
    .ADDR_W     (8),
    .WAIT_STATES(3)
  ) dut3 (
    .clk(clk), .Nrst(Nrst), .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .wr_be(wr_be), .rw_wait(w3), .rd_data(r3)
  );

  // Which responder owns an address (0 = none); equals its wait-state count.
  function automatic int unsigned target(input logic [31:0] a);
    if (a < 32'h1000) return 1;
    if (a < 32'h1400) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic e_w1, input logic e_w3,
                      input logic [31:0] e_r1, input logic [31:0] e_r3);
    @(negedge clk);
    chk({tag, ".wait1"}, 32'(w1), 32'(e_w1));
    chk({tag, ".wait3"}, 32'(w3), 32'(e_w3));
    chk({tag, ".rdata1"}, r1, e_r1);
    chk({tag, ".rdata3"}, r3, e_r3);
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int unsigned t;
    t = target(a);
    if (t == 1) m1[a[11:2]] = merge(m1[a[11:2]], d, be);
    if (t == 3) m3[a[9:2]]  = merge(m3[a[9:2]], d, be);
  endtask

  task automatic access(input string tag, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int unsigned t, resp;
    logic [31:0] expd;
    t    = target(a);
    expd = '0;
    if (!wr && t == 1) expd = m1[a[11:2]];
    if (!wr && t == 3) expd = m3[a[9:2]];
    resp = (t == 0) ? 1 : t + 1;
    busaddr = a; rd_req = rd; wr_req = wr; wr_data = d; wr_be = be;
    for (int unsigned c = 0; c <= resp; c++)
      step(tag, (t == 1) && (c < resp), (t == 3) && (c < resp),
           (t == 1 && c == resp) ? expd : 32'h0, (t == 3 && c == resp) ? expd : 32'h0);
    rd_req = 1'b0; wr_req = 1'b0;
    if (wr) model_write(a, d, be);
    step({tag, ".after"}, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          wr, rd;
    int unsigned idx;

    Nrst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    busaddr = '0; wr_data = '0; wr_be = 4'hF;
    #1;
    step("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    Nrst = 1'b0;
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0);

    access("raw.wr", 1, 0, 32'h40, 32'hCAFEF00D, 4'hF);
    access("raw.rd", 0, 1, 32'h40, 32'h0, 4'hF);

    access("lane.pre", 1, 0, 32'h80, 32'h11223344, 4'hF);
    access("lane.wr",  1, 0, 32'h80, 32'hAABBCCDD, 4'b0101);
    access("lane.rd",  0, 1, 32'h80, 32'h0, 4'hF);

    access("ws3.wr", 1, 0, 32'h1004, 32'h0BAD_BEEF, 4'hF);
    access("ws3.rd", 0, 1, 32'h1004, 32'h0, 4'hF);

    access("oow.rd", 0, 1, 32'h2000, 32'h0, 4'hF);
    access("oow.wr", 1, 0, 32'h2000, 32'hFFFF_FFFF, 4'hF);

    access("both.pre", 1, 0, 32'h44, 32'h0101_0101, 4'hF);
    access("both.rw",  1, 1, 32'h44, 32'h5A5A_A5A5, 4'hF);
    access("both.rd",  0, 1, 32'h44, 32'h0, 4'hF);

    // Abort: retarget a 3-wait write from 0x1010 to 0x1014 in its second WAIT cycle.
    access("abt.pre0", 1, 0, 32'h1010, 32'h1111_0000, 4'hF);
    access("abt.pre1", 1, 0, 32'h1014, 32'h2222_0000, 4'hF);
    busaddr = 32'h1010; wr_req = 1'b1; rd_req = 1'b0; wr_data = 32'h3333_3333; wr_be = 4'hF;
    step("abt.c0", 1'b0, 1'b1, 32'h0, 32'h0);
    step("abt.c1", 1'b0, 1'b1, 32'h0, 32'h0);
    busaddr = 32'h1014;
    for (int c = 2; c <= 6; c++) step("abt.stall", 1'b0, 1'b1, 32'h0, 32'h0);
    step("abt.resp", 1'b0, 1'b0, 32'h0, 32'h0);
    wr_req = 1'b0;
    model_write(32'h1014, 32'h3333_3333, 4'hF);
    step("abt.after", 1'b0, 1'b0, 32'h0, 32'h0);
    access("abt.rd0", 0, 1, 32'h1010, 32'h0, 4'hF);
    access("abt.rd1", 0, 1, 32'h1014, 32'h0, 4'hF);

    // Reset during the WAIT of a write: the write must be lost.
    access("rst.pre", 1, 0, 32'h20, 32'h1234_5678, 4'hF);
    busaddr = 32'h20; wr_req = 1'b1; wr_data = 32'h55; wr_be = 4'hF;
    step("rst.c0", 1'b1, 1'b0, 32'h0, 32'h0);
    Nrst = 1'b1;
    step("rst.hold", 1'b1, 1'b0, 32'h0, 32'h0);
    wr_req = 1'b0; Nrst = 1'b0;
    step("rst.rel", 1'b0, 1'b0, 32'h0, 32'h0);
    access("rst.rd", 0, 1, 32'h20, 32'h0, 4'hF);

    for (int unsigned i = 0; i < 8; i++) begin
      access("rnd.pre1", 1, 0, 32'h100 + 32'(i * 4), $urandom, 4'hF);
      access("rnd.pre3", 1, 0, 32'h1100 + 32'(i * 4), $urandom, 4'hF);
    end
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 7);
      a   = (($urandom_range(0, 1) == 0) ? 32'h100 : 32'h1100) + 32'(idx * 4);
      wr  = bit'($urandom_range(0, 1));
      rd  = wr ? bit'($urandom_range(0, 1)) : 1'b1;
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      access("rnd", wr, rd, a, d, be);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
